axi_read_slave: RTL and testbench

- AXI3-style read slave that sits directly downstream of the read master.
- Accepts read-address requests on the AR channel, queues them, then returns read-data bursts on the R channel from an internal word memory.
- Honours RREADY backpressure and generates RLAST and RRESP.
- Memory is preloaded by the testbench through a backdoor write port.

---
 rtl/axi_read_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_read_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_slave.sv
// AXI3 read slave: queued AR requests, R bursts served from a word memory.
// Memory is loaded through a backdoor port; out-of-range or illegal bursts answer SLVERR.
module axi_read_slave #(
    parameter int BusWidth = 32,
    parameter int tagbits  = 1,
    parameter int MemDepth = 64,
    parameter int QDepth   = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        mem_we,
    input  logic [$clog2(MemDepth)-1:0] mem_waddr,
    input  logic [BusWidth-1:0]         mem_wdata,
    input  logic [tagbits-1:0]          ARID,
    input  logic [BusWidth-1:0]         ARADDR,
    input  logic [3:0]                  ARLEN,
    input  logic [1:0]                  ARSIZE,
    input  logic [1:0]                  ARBURST,
    input  logic [1:0]                  ARLOCK,
    input  logic [3:0]                  ARCACHE,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [tagbits-1:0]          RID,
    output logic [BusWidth-1:0]         RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY
);
    localparam int AW   = $clog2(MemDepth);
    localparam int QW   = $clog2(QDepth);
    localparam int OffW = $clog2(BusWidth / 8);

    typedef struct packed {
        logic [tagbits-1:0]  id;
        logic [BusWidth-1:0] addr;
        logic [3:0]          len;
        logic [1:0]          size;
        logic [1:0]          burst;
    } req_t;

    typedef enum logic {IDLE, SEND} state_t;

    logic [BusWidth-1:0] mem [MemDepth];
    req_t                q_mem [QDepth];
    logic [QW-1:0]       wptr_q, rptr_q;
    logic [QW:0]         cnt_q, cnt_d;
    logic                push, pop, empty;
    req_t                head;

    state_t              state_q, state_d;
    logic [tagbits-1:0]  rid_q, rid_d;
    logic [BusWidth-1:0] rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rlast_q, rlast_d;
    logic                rvalid_q, rvalid_d;
    logic [BusWidth-1:0] addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [3:0]          beat_q, beat_d;
    logic                err_q, err_d;

    logic [BusWidth-1:0] beat_addr, word;
    logic                beat_err, oob, upd;
    logic                unused_ok;

    assign unused_ok = ^{ARLOCK, ARCACHE, ARPROT};

    function automatic logic burst_err(
        input logic [BusWidth-1:0] a,
        input logic [3:0]          len,
        input logic [1:0]          size,
        input logic [1:0]          burst
    );
        logic [BusWidth-1:0] nb;
        logic                len_ok;
        nb     = BusWidth'(1) << size;
        len_ok = (len == 4'd1) || (len == 4'd3) ||
                 (len == 4'd7) || (len == 4'd15);
        return (burst == 2'b11) || (int'(size) > OffW) ||
               ((burst == 2'b10) && (!len_ok || ((a & (nb - 1'b1)) != '0)));
    endfunction

    function automatic logic [BusWidth-1:0] next_addr(
        input logic [BusWidth-1:0] a,
        input logic [3:0]          len,
        input logic [1:0]          size,
        input logic [1:0]          burst
    );
        logic [BusWidth-1:0] nb, bnd;
        nb  = BusWidth'(1) << size;
        bnd = nb * (BusWidth'(len) + BusWidth'(1));
        case (burst)
            2'b01:   return a + nb;
            2'b10:   return (a & ~(bnd - 1'b1)) | ((a + nb) & (bnd - 1'b1));
            default: return a;
        endcase
    endfunction

    always_ff @(posedge ACLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign empty   = (cnt_q == '0);
    assign ARREADY = (cnt_q != (QW + 1)'(QDepth));
    assign push    = ARVALID && ARREADY;
    assign head    = q_mem[rptr_q];

    always_ff @(posedge ACLK) begin
        if (push) q_mem[wptr_q] <= '{ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign word = beat_addr >> OffW;
    assign oob  = (word >= BusWidth'(MemDepth));

    always_comb begin
        state_d   = state_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rvalid_d  = rvalid_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        pop       = 1'b0;
        upd       = 1'b0;
        beat_addr = next_addr(addr_q, len_q, size_q, burst_q);
        beat_err  = err_q;
        case (state_q)
            IDLE: begin
                rvalid_d = 1'b0;
                pop      = !empty;
            end
            SEND: begin
                if (rvalid_q && RREADY) begin
                    if (!rlast_q) begin
                        upd     = 1'b1;
                        addr_d  = beat_addr;
                        beat_d  = beat_q + 4'd1;
                        rlast_d = ((beat_q + 4'd1) == len_q);
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A pop loads the head request and presents its first beat next cycle
        if (pop) begin
            upd       = 1'b1;
            beat_addr = head.addr;
            beat_err  = burst_err(head.addr, head.len, head.size, head.burst);
            rid_d     = head.id;
            addr_d    = head.addr;
            len_d     = head.len;
            size_d    = head.size;
            burst_d   = head.burst;
            err_d     = beat_err;
            beat_d    = 4'd0;
            rlast_d   = (head.len == 4'd0);
            rvalid_d  = 1'b1;
            state_d   = SEND;
        end
        if (upd) begin
            rdata_d = (beat_err || oob) ? '0 : mem[word[AW-1:0]];
            rresp_d = (beat_err || oob) ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    assign RID    = rid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;
    assign RLAST  = rlast_q;
    assign RVALID = rvalid_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Bench for axi_read_slave: expected beats queued per request, popped on R handshakes.
// Covers latency, burst types, backpressure, queueing, SLVERR and mid-burst reset.
module tb_axi_read_slave;
    localparam int MD = 64;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        mem_we = 1'b0;
    logic [5:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic [0:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [1:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic [1:0]  ARLOCK = '0;
    logic [3:0]  ARCACHE = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [0:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    axi_read_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [0:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tbmem[MD];
    int          checks = 0;
    int          errors = 0;

    task automatic model(input logic [0:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] size,
                         input logic [1:0] burst);
        logic [31:0] a, nb, bnd, w;
        logic        berr, oob;
        exp_t        e;
        nb   = 32'd1 << size;
        bnd  = nb * (32'(len) + 32'd1);
        berr = (burst == 2'b11) || (size == 2'd3) ||
               ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
               ((burst == 2'b10) && ((addr % nb) != 0));
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            w      = a >> 2;
            oob    = (w >= 32'(MD));
            e.id   = id;
            e.data = (berr || oob) ? 32'd0 : tbmem[w[5:0]];
            e.resp = (berr || oob) ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            sb.push_back(e);
            case (burst)
                2'b01:   a = a + nb;
                2'b10:   a = (a & ~(bnd - 1)) | ((a + nb) & (bnd - 1));
                default: a = a;
            endcase
        end
    endtask

    task automatic preload();
        for (int i = 0; i < MD; i++) begin
            tbmem[i]  = (i < 4) ? (32'hA0 + 32'(i)) : (32'h1000 + 32'(i) * 32'h11);
            mem_we    = 1'b1;
            mem_waddr = 6'(i);
            mem_wdata = tbmem[i];
            @(posedge ACLK); #1;
        end
        mem_we = 1'b0;
    endtask

    task automatic send_ar(input logic [0:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] size,
                           input logic [1:0] burst);
        int n;
        model(id, addr, len, size, burst);
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        ARLOCK  = 2'($urandom_range(0, 3));
        ARCACHE = 4'($urandom_range(0, 15));
        ARPROT  = 3'($urandom_range(0, 7));
        ARVALID = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge ACLK);
            if (ARREADY) break;
            @(posedge ACLK); #1;
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout got ARREADY=0 exp 1");
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic drain(input string nm, input int n, input int stall_at,
                         input int stall_cyc, input bit nogap);
        int   got, stalled, gaps;
        exp_t e;
        got = 0;
        stalled = 0;
        gaps = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            RREADY = !((got == stall_at) && (stalled < stall_cyc));
            if (!RREADY) stalled++;
            @(negedge ACLK);
            if (RVALID) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_extra got beat %h exp none", nm, RDATA);
                end else if (RREADY) begin
                    e = sb.pop_front();
                    checks++;
                    if (RDATA !== e.data || RID !== e.id ||
                        RRESP !== e.resp || RLAST !== e.last) begin
                        errors++;
                        $display("FAIL %s_beat%0d got d=%h id=%h r=%b l=%b exp d=%h id=%h r=%b l=%b",
                                 nm, got, RDATA, RID, RRESP, RLAST,
                                 e.data, e.id, e.resp, e.last);
                    end
                    got++;
                end else begin
                    checks++;
                    if (RDATA !== sb[0].data || RLAST !== sb[0].last) begin
                        errors++;
                        $display("FAIL %s_hold got d=%h l=%b exp d=%h l=%b",
                                 nm, RDATA, RLAST, sb[0].data, sb[0].last);
                    end
                end
            end else if (got > 0 && got < n) begin
                gaps++;
            end else if (stall_at >= 0 && got == stall_at && stalled > 0) begin
                gaps++;
            end
            @(posedge ACLK); #1;
            if (got == n) break;
        end
        RREADY = 1'b0;
        if (got != n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d beats exp %0d", nm, got, n);
        end
        if (nogap || stall_cyc > 0) begin
            checks++;
            if (gaps != 0) begin
                errors++;
                $display("FAIL %s_gap got %0d idle cycles exp 0", nm, gaps);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== 32'd0 ||
            RID !== 1'b0 || RRESP !== 2'b00 || ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset got v=%b l=%b d=%h id=%h r=%b ar=%b exp 0 0 0 0 0 1",
                     RVALID, RLAST, RDATA, RID, RRESP, ARREADY);
        end
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_incr();
        send_ar(1'b1, 32'h0, 4'd3, 2'd2, 2'b01);
        @(negedge ACLK);
        checks++;
        if (RVALID !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got RVALID=%b exp 0", RVALID);
        end
        @(posedge ACLK); #1;
        checks++;
        if (RVALID !== 1'b1) begin
            errors++;
            $display("FAIL latency got RVALID=%b exp 1", RVALID);
        end
        drain("incr", 4, -1, 0, 1'b1);
    endtask

    task automatic test_wrap_fixed();
        send_ar(1'b0, 32'h8, 4'd3, 2'd2, 2'b10);
        drain("wrap", 4, -1, 0, 1'b1);
        send_ar(1'b1, 32'h4, 4'd2, 2'd2, 2'b00);
        drain("fixed", 3, -1, 0, 1'b1);
        send_ar(1'b0, 32'h21, 4'd3, 2'd0, 2'b10);
        drain("wrap_narrow", 4, -1, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        send_ar(1'b1, 32'h0, 4'd3, 2'd2, 2'b01);
        drain("bp", 4, 1, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        RREADY = 1'b0;
        send_ar(1'b0, 32'h10, 4'd1, 2'd2, 2'b01);
        send_ar(1'b1, 32'h20, 4'd0, 2'd2, 2'b01);
        send_ar(1'b0, 32'h30, 4'd2, 2'd2, 2'b01);
        checks++;
        if (ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL queue_full got ARREADY=%b exp 0", ARREADY);
        end
        drain("b2b", 6, -1, 0, 1'b1);
        checks++;
        if (ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL queue_empty got ARREADY=%b exp 1", ARREADY);
        end
    endtask

    task automatic test_errors();
        send_ar(1'b1, 32'h0, 4'd1, 2'd2, 2'b11);
        drain("err_burst", 2, -1, 0, 1'b1);
        send_ar(1'b0, 32'h100, 4'd0, 2'd2, 2'b01);
        drain("err_oob", 1, -1, 0, 1'b1);
        send_ar(1'b1, 32'h0, 4'd0, 2'd3, 2'b01);
        drain("err_size", 1, -1, 0, 1'b1);
        send_ar(1'b0, 32'h0, 4'd2, 2'd2, 2'b10);
        drain("err_wraplen", 3, -1, 0, 1'b1);
        send_ar(1'b1, 32'hF8, 4'd3, 2'd2, 2'b01);
        drain("err_cross", 4, -1, 0, 1'b1);
    endtask

    task automatic test_mid_reset();
        send_ar(1'b1, 32'h0, 4'd3, 2'd2, 2'b01);
        drain("pre_rst", 2, -1, 0, 1'b0);
        ARESETn = 1'b0;
        #1;
        checks++;
        if (RVALID !== 1'b0 || RLAST !== 1'b0 || ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%b l=%b ar=%b exp 0 0 1",
                     RVALID, RLAST, ARREADY);
        end
        sb.delete();
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        send_ar(1'b0, 32'h4, 4'd1, 2'd2, 2'b01);
        drain("post_rst", 2, -1, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        preload();
        test_incr();
        test_wrap_fixed();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d beats exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
